// File: rtl/agc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// agc_ctrl_pkg
// Shared definitions for the windowed AGC controller and the level-meter block:
// FSM state encodings, default thresholds and the hang counter width.
// -----------------------------------------------------------------------------
package agc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ACC    = 2'd0,
        ST_CAPT   = 2'd1,
        ST_DECIDE = 2'd2
    } agc_state_t;

    localparam int DEF_PW        = 7;
    localparam int DEF_GW        = 6;
    localparam int DEF_WIN_LOG2  = 10;
    localparam int DEF_HANG      = 4;
    localparam int DEF_HI_TH     = 96;
    localparam int DEF_LO_TH     = 48;
    localparam int DEF_GAIN_INIT = 32;

    // HANG is limited to 0..15
    localparam int HANG_W = 4;

endpackage

// File: rtl/agc_ctrl_win_cnt.sv
// -----------------------------------------------------------------------------
// agc_ctrl_win_cnt
// Free-running window counter.  It advances on enabled clocks and wraps
// naturally at 2**WIN_LOG2-1.  win_end flags the last enabled clock of a window.
// Ports:
//   clk      in   master clock
//   rst      in   asynchronous, active-low reset
//   en       in   count enable
//   win_end  out  en & (count == all ones), combinational
// -----------------------------------------------------------------------------
module agc_ctrl_win_cnt
    import agc_ctrl_pkg::*;
#(
    parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic win_end
);

    logic [WIN_LOG2-1:0] wcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= '0;
        end else if (en) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    assign win_end = en && (wcnt == '1);

endmodule

// File: rtl/agc_ctrl.sv
// -----------------------------------------------------------------------------
// agc_ctrl
// Windowed AGC controller downstream of the peak-magnitude detector.  At each
// window end it latches the detector peak, clears the detector and steps the
// gain index: fast attack on high peaks, hang then slow decay on low peaks.
// Ports:
//   clk       in   master clock
//   rst       in   asynchronous, active-low reset
//   en        in   window counter advance enable
//   hold      in   freeze gain/hang (windows and peak capture continue)
//   peak      in   current maximum from detector
//   pk_clr    out  detector clear, high during reset and during CAPT
//   pk_q      out  peak latched at last window end
//   gain      out  gain index
//   gain_vld  out  one-clock pulse after each gain decision
//   ovl       out  last latched peak was full scale
//
// state  | meaning
// -------+-----------------------------------------------------------
// ACC    | detector accumulating, waiting for window end
// CAPT   | detector cleared, peak latched into pk_q
// DECIDE | gain/hang updated from pk_q unless hold
// -----------------------------------------------------------------------------
module agc_ctrl
    import agc_ctrl_pkg::*;
#(
    parameter int PW        = DEF_PW,
    parameter int GW        = DEF_GW,
    parameter int WIN_LOG2  = DEF_WIN_LOG2,
    parameter int HANG      = DEF_HANG,
    parameter int HI_TH     = DEF_HI_TH,
    parameter int LO_TH     = DEF_LO_TH,
    parameter int GAIN_INIT = DEF_GAIN_INIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          hold,
    input  logic [PW-1:0] peak,
    output logic          pk_clr,
    output logic [PW-1:0] pk_q,
    output logic [GW-1:0] gain,
    output logic          gain_vld,
    output logic          ovl
);

    localparam logic [PW-1:0]     HI_V    = PW'(HI_TH);
    localparam logic [PW-1:0]     LO_V    = PW'(LO_TH);
    localparam logic [GW-1:0]     GINIT_V = GW'(GAIN_INIT);
    localparam logic [HANG_W-1:0] HANG_V  = HANG_W'(HANG);

    agc_state_t        state;
    agc_state_t        state_nxt;
    logic              win_end;
    logic [HANG_W-1:0] hang_cnt;

    logic              pk_clr_nxt;
    logic [PW-1:0]     pk_q_nxt;
    logic              ovl_nxt;
    logic [GW-1:0]     gain_nxt;
    logic              gain_vld_nxt;
    logic [HANG_W-1:0] hang_nxt;

    agc_ctrl_win_cnt #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_win_cnt (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .win_end (win_end)
    );

    // state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_ACC;
            pk_clr   <= 1'b1;
            pk_q     <= '0;
            ovl      <= 1'b0;
            gain     <= GINIT_V;
            gain_vld <= 1'b0;
            hang_cnt <= HANG_V;
        end else begin
            state    <= state_nxt;
            pk_clr   <= pk_clr_nxt;
            pk_q     <= pk_q_nxt;
            ovl      <= ovl_nxt;
            gain     <= gain_nxt;
            gain_vld <= gain_vld_nxt;
            hang_cnt <= hang_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:    if (win_end) state_nxt = ST_CAPT;
            ST_CAPT:   state_nxt = ST_DECIDE;
            ST_DECIDE: state_nxt = ST_ACC;
            default:   state_nxt = ST_ACC;
        endcase
    end

    // Next values for the registered outputs; pk_clr is registered from
    // state_nxt so it is high exactly during the CAPT cycle.
    always_comb begin
        pk_clr_nxt   = (state_nxt == ST_CAPT);
        pk_q_nxt     = pk_q;
        ovl_nxt      = ovl;
        gain_nxt     = gain;
        gain_vld_nxt = 1'b0;
        hang_nxt     = hang_cnt;
        case (state)
            ST_CAPT: begin
                pk_q_nxt = peak;
                ovl_nxt  = (peak == '1);
            end
            ST_DECIDE: begin
                if (!hold) begin
                    gain_vld_nxt = 1'b1;
                    if (pk_q >= HI_V) begin
                        gain_nxt = (gain < GW'(2)) ? '0 : gain - GW'(2);
                        hang_nxt = HANG_V;
                    end else if (pk_q < LO_V) begin
                        if (hang_cnt == '0) begin
                            gain_nxt = (gain == '1) ? gain : gain + GW'(1);
                        end else begin
                            hang_nxt = hang_cnt - HANG_W'(1);
                        end
                    end else begin
                        hang_nxt = HANG_V;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_agc_ctrl.sv
module tb_agc_ctrl;

    localparam int PW   = 7;
    localparam int GW   = 6;
    localparam int WL   = 4;
    localparam int HANG = 2;
    localparam int HI   = 96;
    localparam int LO   = 48;
    localparam int GI   = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          hold;
    logic [PW-1:0] peak;
    logic          pk_clr;
    logic [PW-1:0] pk_q;
    logic [GW-1:0] gain;
    logic          gain_vld;
    logic          ovl;

    always #5 clk = ~clk;

    agc_ctrl #(
        .PW(PW), .GW(GW), .WIN_LOG2(WL), .HANG(HANG),
        .HI_TH(HI), .LO_TH(LO), .GAIN_INIT(GI)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .hold     (hold),
        .peak     (peak),
        .pk_clr   (pk_clr),
        .pk_q     (pk_q),
        .gain     (gain),
        .gain_vld (gain_vld),
        .ovl      (ovl)
    );

    typedef struct {
        int pk;
        bit ov;
        int g;
        bit v;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int m_gain;
    int m_hang;

    // reference model of one window's decision, pushed when the window's stimulus is driven
    task automatic push_expect(input int pk, input bit hld);
        exp_t e;
        e.pk = pk;
        e.ov = (pk == 127);
        if (!hld) begin
            if (pk >= HI) begin
                m_gain = (m_gain < 2) ? 0 : m_gain - 2;
                m_hang = HANG;
            end else if (pk < LO) begin
                if (m_hang == 0) m_gain = (m_gain >= 63) ? 63 : m_gain + 1;
                else m_hang = m_hang - 1;
            end else begin
                m_hang = HANG;
            end
        end
        e.g = m_gain;
        e.v = !hld;
        sb.push_back(e);
    endtask

    task automatic wait_capt(output int ncyc);
        ncyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (pk_clr) begin
                ncyc = i;
                break;
            end
        end
        if (ncyc < 0) begin
            checks++; errors++;
            $display("FAIL wait_capt: actual=no pk_clr in 300 clks required=pulse");
        end
    endtask

    task automatic finish_window(input string tag);
        exp_t e;
        @(posedge clk); #1;
        checks++;
        if (pk_clr !== 1'b0) begin
            errors++;
            $display("FAIL %s pk_clr_width: actual=%b required=0", tag, pk_clr);
        end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard: actual=empty required=entry", tag);
        end else begin
            e = sb.pop_front();
            checks++;
            if (int'(pk_q) !== e.pk) begin
                errors++;
                $display("FAIL %s pk_q: actual=%0d required=%0d", tag, pk_q, e.pk);
            end
            checks++;
            if (ovl !== e.ov) begin
                errors++;
                $display("FAIL %s ovl: actual=%b required=%b", tag, ovl, e.ov);
            end
            @(posedge clk); #1;
            checks++;
            if (gain_vld !== e.v) begin
                errors++;
                $display("FAIL %s gain_vld: actual=%b required=%b", tag, gain_vld, e.v);
            end
            checks++;
            if (int'(gain) !== e.g) begin
                errors++;
                $display("FAIL %s gain: actual=%0d required=%0d", tag, gain, e.g);
            end
            @(posedge clk); #1;
            checks++;
            if (gain_vld !== 1'b0) begin
                errors++;
                $display("FAIL %s gain_vld_width: actual=%b required=0", tag, gain_vld);
            end
        end
    endtask

    task automatic run_window(input int pk, input bit hld, input string tag);
        int n;
        peak = PW'(pk);
        hold = hld;
        push_expect(pk, hld);
        wait_capt(n);
        if (n > 0) finish_window(tag);
        else void'(sb.pop_back());
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (pk_clr !== 1'b1 || int'(gain) !== GI || pk_q !== '0 || gain_vld !== 1'b0 || ovl !== 1'b0) begin
            errors++;
            $display("FAIL %s reset_vals: actual pk_clr=%b gain=%0d pk_q=%0d vld=%b ovl=%b required 1/%0d/0/0/0",
                     tag, pk_clr, gain, pk_q, gain_vld, ovl, GI);
        end
    endtask

    task automatic release_and_first_window(input int pk, input string tag);
        int n;
        m_gain = GI;
        m_hang = HANG;
        peak = PW'(pk);
        hold = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        push_expect(pk, 1'b0);
        wait_capt(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL %s first_capt_clks: actual=%0d required=16", tag, n);
        end
        if (n > 0) finish_window(tag);
        else void'(sb.pop_back());
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        en   = 1'b0;
        hold = 1'b0;
        peak = '0;
        #12;
        check_reset_vals("reset");
        release_and_first_window(60, "reset_win");
    endtask

    task automatic test_attack();
        for (int i = 0; i < 3; i++) run_window(100, 1'b0, "attack");
    endtask

    task automatic test_hang_decay();
        for (int i = 0; i < 4; i++) run_window(20, 1'b0, "hang_decay");
    endtask

    task automatic test_in_band();
        run_window(60, 1'b0, "in_band");
        for (int i = 0; i < 3; i++) run_window(20, 1'b0, "in_band_low");
    endtask

    task automatic test_ceiling();
        int k = 0;
        while (m_gain < 63 && k < 40) begin
            run_window(20, 1'b0, "ceiling_ramp");
            k++;
        end
        run_window(20, 1'b0, "ceiling_hold");
        run_window(20, 1'b0, "ceiling_hold");
    endtask

    task automatic test_floor();
        int k = 0;
        while (m_gain > 0 && k < 40) begin
            run_window(127, 1'b0, "floor_ramp");
            k++;
        end
        run_window(127, 1'b0, "floor_hold");
    endtask

    task automatic test_hold();
        run_window(20, 1'b1, "hold_low");
        run_window(100, 1'b1, "hold_high");
        run_window(60, 1'b1, "hold_band");
        for (int i = 0; i < 3; i++) run_window(20, 1'b0, "after_hold");
    endtask

    task automatic test_en_gaps();
        int rises = 0;
        int first = 0;
        int second = 0;
        run_window(60, 1'b0, "gap_pre");
        peak = PW'(60);
        hold = 1'b0;
        for (int i = 1; i <= 200 && rises < 2; i++) begin
            @(posedge clk); #1;
            en = ~en;
            if (pk_clr) begin
                rises++;
                if (rises == 1) first = i;
                else second = i;
            end
        end
        en = 1'b1;
        checks++;
        if (rises < 2 || (second - first) != 32) begin
            errors++;
            $display("FAIL en_gap_period: actual=%0d required=32 (rises=%0d)", second - first, rises);
        end
        if (rises == 2) begin
            push_expect(60, 1'b0);
            finish_window("en_gap");
        end
    endtask

    task automatic test_mid_reset();
        peak = PW'(100);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        release_and_first_window(100, "mid_reset_win");
    endtask

    initial begin
        test_reset();
        test_attack();
        test_hang_decay();
        test_in_band();
        test_ceiling();
        test_floor();
        test_hold();
        test_en_gaps();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
